// File: rtl/ball_motion_pkg.sv
// Shared widths, FSM encoding and default table bounds for the ball motion engine.
package ball_motion_pkg;

    localparam int unsigned FRAC_W = 4;
    localparam int unsigned POS_W  = 15;
    localparam int unsigned VEL_W  = 10;
    localparam int unsigned PIX_W  = POS_W - FRAC_W;

    typedef enum logic [1:0] {
        StIdle,
        StMoving,
        StUpdate
    } state_e;

    localparam logic [PIX_W-1:0] DEF_X_MIN  = 11'd16;
    localparam logic [PIX_W-1:0] DEF_X_MAX  = 11'd1007;
    localparam logic [PIX_W-1:0] DEF_Y_MIN  = 11'd16;
    localparam logic [PIX_W-1:0] DEF_Y_MAX  = 11'd751;
    localparam logic [PIX_W-1:0] DEF_INIT_X = 11'd512;
    localparam logic [PIX_W-1:0] DEF_INIT_Y = 11'd384;
    localparam logic [3:0]       DEF_FRICTION_PERIOD = 4'd4;

endpackage

// File: rtl/ball_motion_axis_step.sv
// One-axis frame step: add velocity, reflect off the cushions, clamp, then apply friction.
module axis_step
    import ball_motion_pkg::*;
(
    input  logic        [POS_W-1:0] pos_i,
    input  logic signed [VEL_W-1:0] vel_i,
    input  logic        [PIX_W-1:0] min_i,
    input  logic        [PIX_W-1:0] max_i,
    input  logic                    friction_i,
    output logic        [POS_W-1:0] pos_o,
    output logic signed [VEL_W-1:0] vel_o,
    output logic                    bounce_o
);

    // Wider than the 16 bits strictly needed so 2*bound - next can never wrap.
    logic signed [17:0] next_pos;
    logic signed [17:0] lo_bound;
    logic signed [17:0] hi_bound;
    logic signed [17:0] refl_pos;
    logic signed [VEL_W-1:0] vel_refl;

    always_comb begin
        lo_bound = $signed({3'b000, min_i, 4'b0000});
        hi_bound = $signed({3'b000, max_i, 4'b0000});
        next_pos = $signed({3'b000, pos_i}) + $signed({{8{vel_i[VEL_W-1]}}, vel_i});
        refl_pos = next_pos;
        vel_refl = vel_i;
        bounce_o = 1'b0;

        if (next_pos > hi_bound) begin
            refl_pos = (hi_bound <<< 1) - next_pos;
            vel_refl = -vel_i;
            bounce_o = 1'b1;
        end else if (next_pos < lo_bound) begin
            refl_pos = (lo_bound <<< 1) - next_pos;
            vel_refl = -vel_i;
            bounce_o = 1'b1;
        end

        if (refl_pos > hi_bound) begin
            refl_pos = hi_bound;
        end else if (refl_pos < lo_bound) begin
            refl_pos = lo_bound;
        end
        pos_o = refl_pos[POS_W-1:0];

        vel_o = vel_refl;
        if (friction_i && (vel_refl != '0)) begin
            vel_o = vel_refl[VEL_W-1] ? vel_refl + 10'sd1 : vel_refl - 10'sd1;
        end
    end

endmodule

// File: rtl/ball_motion.sv
// Per-ball motion engine: fixed-point position/velocity advanced once per frame_tick.
module ball_motion
    import ball_motion_pkg::*;
#(
    parameter logic [PIX_W-1:0] X_MIN           = DEF_X_MIN,
    parameter logic [PIX_W-1:0] X_MAX           = DEF_X_MAX,
    parameter logic [PIX_W-1:0] Y_MIN           = DEF_Y_MIN,
    parameter logic [PIX_W-1:0] Y_MAX           = DEF_Y_MAX,
    parameter logic [PIX_W-1:0] INIT_X          = DEF_INIT_X,
    parameter logic [PIX_W-1:0] INIT_Y          = DEF_INIT_Y,
    parameter logic [3:0]       FRICTION_PERIOD = DEF_FRICTION_PERIOD
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             frame_tick,
    input  logic             strike_valid,
    input  logic [VEL_W-1:0] strike_vx,
    input  logic [VEL_W-1:0] strike_vy,
    output logic             strike_ready,
    input  logic             load_valid,
    input  logic [PIX_W-1:0] load_x,
    input  logic [PIX_W-1:0] load_y,
    output logic [PIX_W-1:0] x,
    output logic [PIX_W-1:0] y,
    output logic             moving,
    output logic             bounce
);

    state_e                  state_q, state_d;
    logic        [POS_W-1:0] px_q, px_d, py_q, py_d;
    logic signed [VEL_W-1:0] vx_q, vx_d, vy_q, vy_d;
    logic        [3:0]       fcnt_q, fcnt_d;
    logic                    bounce_q, bounce_d;
    logic                    moving_q, moving_d;
    logic                    ready_q, ready_d;

    logic        [3:0]       fcnt_inc;
    logic                    fric_hit;
    logic        [POS_W-1:0] ax_pos, ay_pos;
    logic signed [VEL_W-1:0] ax_vel, ay_vel;
    logic                    ax_bounce, ay_bounce;

    assign fcnt_inc = fcnt_q + 4'd1;
    assign fric_hit = (fcnt_inc == FRICTION_PERIOD);

    axis_step u_axis_x (
        .pos_i      (px_q),
        .vel_i      (vx_q),
        .min_i      (X_MIN),
        .max_i      (X_MAX),
        .friction_i (fric_hit),
        .pos_o      (ax_pos),
        .vel_o      (ax_vel),
        .bounce_o   (ax_bounce)
    );

    axis_step u_axis_y (
        .pos_i      (py_q),
        .vel_i      (vy_q),
        .min_i      (Y_MIN),
        .max_i      (Y_MAX),
        .friction_i (fric_hit),
        .pos_o      (ay_pos),
        .vel_o      (ay_vel),
        .bounce_o   (ay_bounce)
    );

    always_comb begin
        state_d  = state_q;
        px_d     = px_q;
        py_d     = py_q;
        vx_d     = vx_q;
        vy_d     = vy_q;
        fcnt_d   = fcnt_q;
        bounce_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Load has priority; a simultaneous strike is simply not taken.
                if (load_valid) begin
                    px_d = {load_x, 4'b0000};
                    py_d = {load_y, 4'b0000};
                end else if (strike_valid) begin
                    vx_d   = $signed(strike_vx);
                    vy_d   = $signed(strike_vy);
                    fcnt_d = '0;
                    if ((strike_vx != '0) || (strike_vy != '0)) begin
                        state_d = StMoving;
                    end
                end
            end
            StMoving: begin
                if (frame_tick) begin
                    state_d = StUpdate;
                end
            end
            StUpdate: begin
                px_d     = ax_pos;
                py_d     = ay_pos;
                vx_d     = ax_vel;
                vy_d     = ay_vel;
                bounce_d = ax_bounce | ay_bounce;
                fcnt_d   = fric_hit ? 4'd0 : fcnt_inc;
                state_d  = ((ax_vel == '0) && (ay_vel == '0)) ? StIdle : StMoving;
            end
            default: state_d = StIdle;
        endcase

        moving_d = (state_d != StIdle);
        ready_d  = (state_d == StIdle);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            px_q     <= {INIT_X, 4'b0000};
            py_q     <= {INIT_Y, 4'b0000};
            vx_q     <= '0;
            vy_q     <= '0;
            fcnt_q   <= '0;
            bounce_q <= 1'b0;
            moving_q <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            px_q     <= px_d;
            py_q     <= py_d;
            vx_q     <= vx_d;
            vy_q     <= vy_d;
            fcnt_q   <= fcnt_d;
            bounce_q <= bounce_d;
            moving_q <= moving_d;
            ready_q  <= ready_d;
        end
    end

    assign x            = px_q[POS_W-1:FRAC_W];
    assign y            = py_q[POS_W-1:FRAC_W];
    assign moving       = moving_q;
    assign bounce       = bounce_q;
    assign strike_ready = ready_q;

endmodule

// File: tb/tb_ball_motion.sv
// Directed self-checking bench for ball_motion: vector table plus handshake/timing sequences.
module tb_ball_motion;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        strike_valid = 1'b0;
    logic [9:0]  strike_vx = '0;
    logic [9:0]  strike_vy = '0;
    logic        load_valid = 1'b0;
    logic [10:0] load_x = '0;
    logic [10:0] load_y = '0;
    logic        strike_ready;
    logic [10:0] x;
    logic [10:0] y;
    logic        moving;
    logic        bounce;

    int errors = 0;
    int checks = 0;
    int bounces;

    typedef struct {
        logic [10:0]       lx;
        logic [10:0]       ly;
        logic signed [9:0] vx;
        logic signed [9:0] vy;
        int                ticks;
        int                ex;
        int                ey;
        int                evx;
        int                evy;
        int                emov;
        int                ebnc;
    } vec_t;

    vec_t vecs[8];

    always #5 clock = ~clock;

    ball_motion dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .frame_tick   (frame_tick),
        .strike_valid (strike_valid),
        .strike_vx    (strike_vx),
        .strike_vy    (strike_vy),
        .strike_ready (strike_ready),
        .load_valid   (load_valid),
        .load_x       (load_x),
        .load_y       (load_y),
        .x            (x),
        .y            (y),
        .moving       (moving),
        .bounce       (bounce)
    );

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // All tasks start and end just after a falling edge.
    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic do_load(input logic [10:0] lx, input logic [10:0] ly);
        load_x = lx;
        load_y = ly;
        load_valid = 1'b1;
        @(negedge clock);
        load_valid = 1'b0;
    endtask

    task automatic do_strike(input logic [9:0] vx, input logic [9:0] vy);
        strike_vx = vx;
        strike_vy = vy;
        strike_valid = 1'b1;
        @(negedge clock);
        strike_valid = 1'b0;
    endtask

    task automatic do_tick();
        frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
        if (bounce) bounces++;
        @(negedge clock);
        if (bounce) bounces++;
        @(negedge clock);
        if (bounce) bounces++;
    endtask

    initial begin
        vecs[0] = '{11'd512,  11'd384, 10'sd32,  10'sd0,    4, 520,  384, 31,  0,   1, 0};
        vecs[1] = '{11'd1006, 11'd384, 10'sd48,  10'sd0,    1, 1005, 384, -48, 0,   1, 1};
        vecs[2] = '{11'd17,   11'd17,  -10'sd48, -10'sd48,  1, 18,   18,  48,  48,  1, 1};
        vecs[3] = '{11'd512,  11'd384, 10'sd1,   10'sd0,    4, 512,  384, 0,   0,   0, 0};
        vecs[4] = '{11'd512,  11'd20,  10'sd0,   -10'sd100, 1, 512,  18,  0,   100, 1, 1};
        vecs[5] = '{11'd512,  11'd750, 10'sd0,   10'sd40,   1, 512,  749, 0,   -40, 1, 1};
        vecs[6] = '{11'd1004, 11'd384, 10'sd48,  10'sd0,    1, 1007, 384, 48,  0,   1, 0};
        vecs[7] = '{11'd512,  11'd384, -10'sd2,  10'sd0,    4, 511,  384, -1,  0,   1, 0};

        // Reset state
        @(negedge clock);
        chk("reset_x_held", x, 512);
        chk("reset_y_held", y, 384);
        do_reset();
        chk("reset_x", x, 512);
        chk("reset_y", y, 384);
        chk("reset_ready", strike_ready, 1);
        chk("reset_moving", moving, 0);
        chk("reset_bounce", bounce, 0);

        foreach (vecs[i]) begin
            do_reset();
            do_load(vecs[i].lx, vecs[i].ly);
            do_strike(vecs[i].vx, vecs[i].vy);
            bounces = 0;
            for (int t = 0; t < vecs[i].ticks; t++) do_tick();
            chk($sformatf("v%0d_x", i), x, vecs[i].ex);
            chk($sformatf("v%0d_y", i), y, vecs[i].ey);
            chk($sformatf("v%0d_vx", i), $signed(dut.vx_q), vecs[i].evx);
            chk($sformatf("v%0d_vy", i), $signed(dut.vy_q), vecs[i].evy);
            chk($sformatf("v%0d_moving", i), moving, vecs[i].emov);
            chk($sformatf("v%0d_ready", i), strike_ready, 1 - vecs[i].emov);
            chk($sformatf("v%0d_bounces", i), bounces, vecs[i].ebnc);
        end

        // Strike latency and per-tick position sequence
        do_reset();
        do_strike(10'sd32, 10'sd0);
        chk("strike_moving_t1", moving, 1);
        chk("strike_ready_t1", strike_ready, 0);
        for (int t = 1; t <= 4; t++) begin
            frame_tick = 1'b1;
            @(negedge clock);
            frame_tick = 1'b0;
            chk($sformatf("tick%0d_x_t1", t), x, 512 + 2 * (t - 1));
            @(negedge clock);
            chk($sformatf("tick%0d_x_t2", t), x, 512 + 2 * t);
            @(negedge clock);
        end

        // Bounce pulse width and position
        do_reset();
        do_load(11'd1006, 11'd384);
        do_strike(10'sd48, 10'sd0);
        frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
        chk("bounce_t1", bounce, 0);
        @(negedge clock);
        chk("bounce_t2", bounce, 1);
        chk("bounce_x_t2", x, 1005);
        @(negedge clock);
        chk("bounce_t3", bounce, 0);

        // Strike coincident with tick in IDLE: the tick is dropped
        do_reset();
        strike_vx = 10'sd32;
        strike_vy = 10'sd0;
        strike_valid = 1'b1;
        frame_tick = 1'b1;
        @(negedge clock);
        strike_valid = 1'b0;
        frame_tick = 1'b0;
        chk("st_tick_moving", moving, 1);
        repeat (3) @(negedge clock);
        chk("st_tick_no_motion", x, 512);
        do_tick();
        chk("st_tick_next_tick", x, 514);

        // Strike and load while moving are ignored
        load_x = 11'd100;
        load_y = 11'd100;
        load_valid = 1'b1;
        strike_vx = -10'sd5;
        strike_valid = 1'b1;
        @(negedge clock);
        load_valid = 1'b0;
        strike_valid = 1'b0;
        @(negedge clock);
        chk("busy_load_x", x, 514);
        chk("busy_load_y", y, 384);
        chk("busy_strike_vx", $signed(dut.vx_q), 32);

        // Load and strike together in IDLE: load wins
        do_reset();
        load_x = 11'd700;
        load_y = 11'd300;
        load_valid = 1'b1;
        strike_vx = 10'sd32;
        strike_vy = 10'sd0;
        strike_valid = 1'b1;
        @(negedge clock);
        load_valid = 1'b0;
        strike_valid = 1'b0;
        chk("ld_st_x", x, 700);
        chk("ld_st_y", y, 300);
        chk("ld_st_ready", strike_ready, 1);
        chk("ld_st_moving", moving, 0);
        chk("ld_st_vx", $signed(dut.vx_q), 0);

        // Zero-velocity strike stays IDLE
        do_strike(10'sd0, 10'sd0);
        chk("zero_strike_ready", strike_ready, 1);
        chk("zero_strike_moving", moving, 0);

        // Asynchronous reset during UPDATE
        do_reset();
        do_load(11'd600, 11'd200);
        do_strike(10'sd32, 10'sd16);
        frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        chk("arst_x", x, 512);
        chk("arst_y", y, 384);
        chk("arst_moving", moving, 0);
        chk("arst_ready", strike_ready, 1);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        chk("arst_x_after", x, 512);
        chk("arst_moving_after", moving, 0);
        chk("arst_vx_after", $signed(dut.vx_q), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
